// File: rtl/seg_scan_driver.sv
// seg_scan_driver: binary-to-BCD converter (sequential double dabble) and
// 4-digit multiplexed, active-low seven-segment scan driver.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter bit          LZ_BLANK = 1'b0
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic [13:0] value,
  input  logic        load,
  input  logic [3:0]  dp,
  output logic [3:0]  AN,
  output logic [7:0]  leds,
  output logic        busy,
  output logic        ovf
);

  localparam int unsigned VAL_W  = 14;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned SR_W   = BCD_W + VAL_W;
  localparam int unsigned DIV_W  = 20;
  localparam int unsigned ITER_W = 4;
  localparam logic [VAL_W-1:0]  MAX_VAL  = VAL_W'(9999);
  localparam logic [ITER_W-1:0] LAST_IT  = ITER_W'(VAL_W - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_COMMIT
  } state_t;

  state_t             state_q;
  logic [SR_W-1:0]    sr_q;
  logic [ITER_W-1:0]  iter_q;
  logic [BCD_W-1:0]   disp_q;
  logic [VAL_W-1:0]   pend_q;
  logic               pend_vld_q;
  logic               busy_q;
  logic               ovf_q;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0]         an_q, an_d;
  logic [7:0]         leds_q, leds_d;
  logic [VAL_W-1:0]   start_val_c;
  logic [3:0]         digit_c;
  logic               blank_c;
  logic [6:0]         seg_c;

  // Clamp to the largest displayable value.
  function automatic logic [VAL_W-1:0] sat(input logic [VAL_W-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  // One double-dabble iteration: add 3 to each BCD nibble >= 5, then shift left.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int i = 0; i < 4; i++) begin
      if (t[VAL_W + 4*i +: 4] >= 4'd5) begin
        t[VAL_W + 4*i +: 4] = t[VAL_W + 4*i +: 4] + 4'd3;
      end
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  // Value entering the converter straight out of COMMIT: a same-cycle load beats the pending entry.
  always_comb begin
    start_val_c = pend_q;
    if (load) begin
      start_val_c = value;
    end
  end

  // Conversion FSM with pending-load slot and atomic display commit.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      iter_q     <= '0;
      disp_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            sr_q    <= {BCD_W'(0), sat(value)};
            ovf_q   <= (value > MAX_VAL);
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_CONV;
          end
        end
        ST_CONV: begin
          sr_q   <= dabble_step(sr_q);
          iter_q <= iter_q + ITER_W'(1);
          if (load) begin
            pend_q     <= value;
            pend_vld_q <= 1'b1;
          end
          if (iter_q == LAST_IT) begin
            state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          disp_q <= sr_q[SR_W-1:VAL_W];
          if (load || pend_vld_q) begin
            sr_q       <= {BCD_W'(0), sat(start_val_c)};
            ovf_q      <= (start_val_c > MAX_VAL);
            iter_q     <= '0;
            pend_vld_q <= 1'b0;
            state_q    <= ST_CONV;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Scan divider/index next state and the digit/anode/segment image for the current index.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end

    digit_c = disp_q[15:12];
    blank_c = 1'b0;
    an_d    = 4'b0111;
    case (idx_q)
      2'd0: begin
        digit_c = disp_q[15:12];
        blank_c = LZ_BLANK && (disp_q[15:12] == 4'd0);
        an_d    = 4'b0111;
      end
      2'd1: begin
        digit_c = disp_q[11:8];
        blank_c = LZ_BLANK && (disp_q[15:8] == 8'd0);
        an_d    = 4'b1011;
      end
      2'd2: begin
        digit_c = disp_q[7:4];
        blank_c = LZ_BLANK && (disp_q[15:4] == 12'd0);
        an_d    = 4'b1101;
      end
      default: begin
        digit_c = disp_q[3:0];
        blank_c = 1'b0;
        an_d    = 4'b1110;
      end
    endcase

    case (digit_c)
      4'd0:    seg_c = 7'b1000000;
      4'd1:    seg_c = 7'b1111001;
      4'd2:    seg_c = 7'b0100100;
      4'd3:    seg_c = 7'b0110000;
      4'd4:    seg_c = 7'b0011001;
      4'd5:    seg_c = 7'b0010010;
      4'd6:    seg_c = 7'b0000010;
      4'd7:    seg_c = 7'b1111000;
      4'd8:    seg_c = 7'b0000000;
      4'd9:    seg_c = 7'b0010000;
      default: seg_c = 7'b1111111;
    endcase
    if (blank_c) begin
      seg_c = 7'b1111111;
    end
    leds_d = {~dp[2'd3 - idx_q], seg_c};
  end

  // Scan registers: anode and segments update together on the same edge.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      div_q  <= '0;
      idx_q  <= '0;
      an_q   <= 4'b1111;
      leds_q <= 8'hFF;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      leds_q <= leds_d;
    end
  end

  assign AN   = an_q;
  assign leds = leds_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus randomized loads,
// checked against an arithmetic model of the displayed number and scan order.
module tb_seg_scan_driver;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  dp = '0;
  logic [3:0]  an0, an1;
  logic [7:0]  leds0, leds1;
  logic        busy0, busy1, ovf0, ovf1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int shown = 0;

  seg_scan_driver #(.SCAN_DIV(SD), .LZ_BLANK(1'b0)) u_dut (
    .sysclk(clk), .rst_n(rst_n), .value(value), .load(load), .dp(dp),
    .AN(an0), .leds(leds0), .busy(busy0), .ovf(ovf0)
  );

  seg_scan_driver #(.SCAN_DIV(SD), .LZ_BLANK(1'b1)) u_dut_lz (
    .sysclk(clk), .rst_n(rst_n), .value(value), .load(load), .dp(dp),
    .AN(an1), .leds(leds1), .busy(busy1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  // Edges since reset release: edge n drives digit ((n-1)/SD)%4.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic int digit_at(input int n);
    return ((n - 1) / SD) % 4;
  endfunction

  function automatic logic [3:0] exp_an(input int n);
    logic [3:0] one;
    one = 4'b1000;
    return ~(one >> digit_at(n));
  endfunction

  function automatic logic [7:0] exp_leds(input int v, input int di, input logic [3:0] dpv, input bit lz);
    int w;
    logic [6:0] s;
    w = (di == 0) ? 1000 : (di == 1) ? 100 : (di == 2) ? 10 : 1;
    if (lz && w > 1 && v < w) s = 7'b1111111;
    else                      s = seg_of((v / w) % 10);
    return {~dpv[3 - di], s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input int v);
    value = 14'(v);
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (an0 !== 4'b1111 || leds0 !== 8'hFF) begin
        fails++;
        $display("FAIL reset_out i=%0d AN=%b leds=%h exp 1111/ff", i, an0, leds0);
      end
      tests++;
      if (busy0 !== 1'b0 || ovf0 !== 1'b0) begin
        fails++;
        $display("FAIL reset_flags i=%0d busy=%b ovf=%b exp 0/0", i, busy0, ovf0);
      end
    end
    rst_n = 1'b1;
    shown = 0;
    for (int i = 0; i < 4 * SD; i++) begin
      tick();
      tests++;
      if (an0 !== exp_an(cyc)) begin
        fails++;
        $display("FAIL post_reset_an cyc=%0d got %b exp %b", cyc, an0, exp_an(cyc));
      end
      tests++;
      if (leds0 !== 8'hC0 || leds1 !== exp_leds(0, digit_at(cyc), 4'b0000, 1'b1)) begin
        fails++;
        $display("FAIL post_reset_leds cyc=%0d got %h/%h exp c0/%h", cyc, leds0, leds1,
                 exp_leds(0, digit_at(cyc), 4'b0000, 1'b1));
      end
    end
  endtask

  // Load one value and follow busy and the display for 31 edges after the load edge.
  task automatic test_load(input int v, input string name);
    int nv;
    nv = (v > 9999) ? 9999 : v;
    pulse_load(v);
    for (int k = 1; k <= 31; k++) begin
      tick();
      if (k == 16) shown = nv;
      tests++;
      if (busy0 !== (k <= 14) || busy1 !== (k <= 14)) begin
        fails++;
        $display("FAIL %s_busy k=%0d got %b/%b exp %b", name, k, busy0, busy1, (k <= 14));
      end
      tests++;
      if (an0 !== exp_an(cyc) || an1 !== exp_an(cyc)) begin
        fails++;
        $display("FAIL %s_an k=%0d got %b/%b exp %b", name, k, an0, an1, exp_an(cyc));
      end
      tests++;
      if (leds0 !== exp_leds(shown, digit_at(cyc), dp, 1'b0) ||
          leds1 !== exp_leds(shown, digit_at(cyc), dp, 1'b1)) begin
        fails++;
        $display("FAIL %s_leds k=%0d got %h/%h exp %h/%h", name, k, leds0, leds1,
                 exp_leds(shown, digit_at(cyc), dp, 1'b0), exp_leds(shown, digit_at(cyc), dp, 1'b1));
      end
    end
    tests++;
    if (ovf0 !== (v > 9999) || ovf1 !== (v > 9999)) begin
      fails++;
      $display("FAIL %s_ovf got %b/%b exp %b", name, ovf0, ovf1, (v > 9999));
    end
  endtask

  task automatic test_decode_3455();
    int got [4];
    int sum;
    dp = 4'b0000;
    test_load(3455, "load3455");
    for (int i = 0; i < 4 * SD; i++) begin
      tick();
      case (an0)
        4'b0111: for (int d = 0; d < 10; d++) if (seg_of(d) == leds0[6:0]) got[0] = d * 1000;
        4'b1011: for (int d = 0; d < 10; d++) if (seg_of(d) == leds0[6:0]) got[1] = d * 100;
        4'b1101: for (int d = 0; d < 10; d++) if (seg_of(d) == leds0[6:0]) got[2] = d * 10;
        4'b1110: for (int d = 0; d < 10; d++) if (seg_of(d) == leds0[6:0]) got[3] = d;
        default: ;
      endcase
    end
    sum = got[0] + got[1] + got[2] + got[3];
    tests++;
    if (sum !== 3455) begin
      fails++;
      $display("FAIL decode_sum got %0d exp 3455", sum);
    end
  endtask

  task automatic test_ovf();
    test_load(12000, "ovf12000");
    test_load(42, "ovf42");
  endtask

  task automatic test_back_to_back();
    dp = 4'b0101;
    pulse_load(1234);
    for (int k = 1; k <= 40; k++) begin
      load = 1'b0;
      if (k == 3) begin value = 14'(5678); load = 1'b1; end
      if (k == 6) begin value = 14'(777);  load = 1'b1; end
      tick();
      load = 1'b0;
      if (k == 16) shown = 1234;
      if (k == 31) shown = 777;
      tests++;
      if (busy0 !== (k <= 29)) begin
        fails++;
        $display("FAIL b2b_busy k=%0d got %b exp %b", k, busy0, (k <= 29));
      end
      tests++;
      if (an0 !== exp_an(cyc) || leds0 !== exp_leds(shown, digit_at(cyc), dp, 1'b0)) begin
        fails++;
        $display("FAIL b2b_disp k=%0d got %b/%h exp %b/%h", k, an0, leds0, exp_an(cyc),
                 exp_leds(shown, digit_at(cyc), dp, 1'b0));
      end
    end
  endtask

  task automatic test_reset_mid();
    dp = 4'b0000;
    pulse_load(8888);
    for (int k = 1; k <= 6; k++) begin
      load = (k == 3);
      value = 14'(1111);
      tick();
      load = 1'b0;
      tests++;
      if (busy0 !== 1'b1) begin
        fails++;
        $display("FAIL mid_busy k=%0d got %b exp 1", k, busy0);
      end
    end
    rst_n = 1'b0;
    tick();
    tests++;
    if (busy0 !== 1'b0 || an0 !== 4'b1111 || leds0 !== 8'hFF) begin
      fails++;
      $display("FAIL mid_reset got busy=%b AN=%b leds=%h exp 0/1111/ff", busy0, an0, leds0);
    end
    rst_n = 1'b1;
    shown = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      tests++;
      if (busy0 !== 1'b0 || an0 !== exp_an(cyc) || leds0 !== exp_leds(0, digit_at(cyc), dp, 1'b0)) begin
        fails++;
        $display("FAIL mid_after k=%0d got busy=%b AN=%b leds=%h exp 0/%b/%h", k, busy0, an0, leds0,
                 exp_an(cyc), exp_leds(0, digit_at(cyc), dp, 1'b0));
      end
    end
    test_load(5, "mid_load5");
    for (int k = 0; k < 20; k++) begin
      tick();
      tests++;
      if (busy0 !== 1'b0 || leds0 !== exp_leds(5, digit_at(cyc), dp, 1'b0)) begin
        fails++;
        $display("FAIL mid_no_pending k=%0d got busy=%b leds=%h exp 0/%h", k, busy0, leds0,
                 exp_leds(5, digit_at(cyc), dp, 1'b0));
      end
    end
  endtask

  task automatic test_lz();
    logic [7:0] want [4];
    dp = 4'b0010;
    test_load(7, "lz7");
    want[0] = 8'hFF; want[1] = 8'hFF; want[2] = 8'h7F; want[3] = 8'hF8;
    for (int i = 0; i < 4 * SD; i++) begin
      tick();
      tests++;
      if (leds1 !== want[digit_at(cyc)]) begin
        fails++;
        $display("FAIL lz7_const cyc=%0d got %h exp %h", cyc, leds1, want[digit_at(cyc)]);
      end
    end
    dp = 4'b0000;
    test_load(0, "lz0");
    want[0] = 8'hFF; want[1] = 8'hFF; want[2] = 8'hFF; want[3] = 8'hC0;
    for (int i = 0; i < 4 * SD; i++) begin
      tick();
      tests++;
      if (leds1 !== want[digit_at(cyc)]) begin
        fails++;
        $display("FAIL lz0_const cyc=%0d got %h exp %h", cyc, leds1, want[digit_at(cyc)]);
      end
    end
  endtask

  task automatic test_random();
    int v;
    for (int it = 0; it < 20; it++) begin
      dp = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) v = int'($urandom_range(0, 99));
      else                           v = int'($urandom_range(0, 16383));
      test_load(v, "rand");
      for (int g = int'($urandom_range(0, 5)); g > 0; g--) tick();
    end
  endtask

  initial begin
    test_reset();
    test_decode_3455();
    test_ovf();
    test_back_to_back();
    test_reset_mid();
    test_lz();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
